int_ctrl: RTL
=============

INT_CTRL -- requirements
Module: int_ctrl

Interface
REQ-001 SHALL provide one clock and one synchronous, active-high reset, named clk and reset respectively.
REQ-002 SHALL have ports (name, direction, width, meaning):
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- irq_in  in  8  external requests; bits [7:2] used, bits [1:0] ignored.
- mask_we  in  1  write strobe for the mask register.
- mask_data  in  8  new mask value; bits [7:2] used.
- s_calli  in  8  interrupt entry from the control unit; bit0 = ALU overflow, bit1 = stack overflow, bits [7:2] = external.
- s_reti  in  8  interrupt return from the control unit; one-hot source being retired.
- min_bit_s  out  8  one-hot highest-priority pending, unmasked request (lowest index wins); 0 = none.
- min_bit_a  out  8  one-hot highest-priority in-service source; 0 = none.
- irq_pending  out  1  OR-reduction of min_bit_s.
- mask_q  out  8  current mask register.
- nest_err  out  1  sticky re-entry error flag.

Function
REQ-003 SHALL keep three registers: pending[7:0], in_service[7:0] and mask[7:0].
REQ-004 SHALL hold pending[1:0] at 0 at all times; these exception bits enter only via s_calli.
REQ-005 SHALL hold mask[1:0] at 1 at all times and write mask[7:2] from mask_data[7:2] on mask_we.
REQ-006 SHALL drive min_bit_s combinationally as the lowest set bit of (pending & mask), isolated to one-hot.
REQ-007 SHALL drive min_bit_a combinationally as the lowest set bit of in_service, isolated to one-hot.
REQ-008 SHALL give a one-cycle capture latency: a request seen at edge n appears on min_bit_s after edge n.
REQ-009 SHALL honour only the lowest set bit of s_calli and of s_reti when either is not one-hot.
REQ-010 SHALL, for the honoured s_calli bit k, clear pending[k] and set in_service[k] at the next edge.
REQ-011 SHALL, for the honoured s_reti bit k, clear in_service[k] at the next edge.
REQ-012 SHALL, when s_calli and s_reti name the same bit, let the call win so that in_service[k] stays 1.
REQ-013 SHALL, when s_calli and s_reti name different bits, apply both in the same cycle.
REQ-014 SHALL, when a new capture and a call clear pending[k] in the same cycle, let the capture win so that pending[k] = 1.
REQ-015 SHALL, when s_calli names a bit already set in in_service, leave in_service unchanged and set nest_err.
REQ-016 SHALL ignore an s_reti for a bit not currently in service, with no state change.
REQ-017 SHALL make a mask write effective on min_bit_s in the following cycle, with pending bits retained while masked.

Reset
REQ-018 SHALL, on reset, set pending = 0x00, in_service = 0x00, mask = 0x03 and nest_err = 0.
REQ-019 SHALL, as a result, drive min_bit_s = 0, min_bit_a = 0, irq_pending = 0 and mask_q = 0x03 after reset.
REQ-020 SHALL let reset override every concurrent call, return, capture or mask write, and SHALL clear edge-detect history.

Configuration
REQ-021 SHALL support one macro, INT_CTRL_EDGE_EN, and SHALL use exactly one capture mode per build.
REQ-022 SHALL, when INT_CTRL_EDGE_EN is defined:
- register irq_in into irq_q, which resets to 0;
- set pending[k] on a rising edge only (irq_in[k] & ~irq_q[k]);
- keep a held-high line from re-triggering after a call.
REQ-023 SHALL, when INT_CTRL_EDGE_EN is not defined:
- capture level-sensitively, with pending[k] set on every cycle irq_in[k] = 1;
- let a held line re-pend immediately after a call;
- include no irq_q register.

Structure
REQ-024 SHALL place in the shared package int_pkg:
- NUM_SRC = 8;
- EXC_ALU = 0 and EXC_STACK = 1;
- MASK_RST = 8'h03;
- the vector type for 8-bit one-hot source vectors.
REQ-025 SHALL implement lowest-set-bit isolation in one sub-module, lowbit_iso (8-bit in, one-hot out), instantiated for min_bit_s, min_bit_a, s_calli and s_reti.

Verification
REQ-026 SHALL cover these directed scenarios:
- Reset, then mask_data=0xFF with mask_we, then irq_in=0x24 -> next cycle min_bit_s=0x04 and irq_pending=1.
- With 0x24 pending, s_calli=0x04 -> pending=0x20, min_bit_a=0x04, min_bit_s=0x20.
- Then s_reti=0x04 together with s_calli=0x20 -> min_bit_a=0x20 and min_bit_s=0x00.
- s_calli=0x01 while in_service=0x01 -> nest_err=1, in_service unchanged; reset -> nest_err=0.
- mask=0x03 with irq_in=0x80 -> min_bit_s=0x00; write mask 0x83 -> next cycle min_bit_s=0x80.
- EDGE_EN build: irq_in[3] held high across s_calli=0x08 -> pending[3]=0 afterwards. Level build: pending[3]=1 on the next cycle.

Source files
------------

// File: rtl/int_pkg.sv
// int_pkg: shared constants and the source-vector type for the interrupt controller.
// Sources 0 and 1 are internal exceptions; sources 7..2 are external request lines.
package int_pkg;

   localparam int NUM_SRC   = 8;
   localparam int EXC_ALU   = 0;
   localparam int EXC_STACK = 1;

   // One bit per interrupt source; used for every one-hot source vector.
   typedef logic [NUM_SRC-1:0] src_vec_t;

   localparam src_vec_t MASK_RST = 8'h03;

   // Exception sources: never captured from irq_in, always unmasked.
   localparam src_vec_t EXC_BITS = src_vec_t'((1 << EXC_ALU) | (1 << EXC_STACK));

endpackage

// File: rtl/int_ctrl_lowbit_iso.sv
// lowbit_iso: isolates the lowest set bit of an 8-bit vector (one-hot out, 0 if none).
// Lowest index means highest priority throughout the controller.
module lowbit_iso
   import int_pkg::*;
(
   input  src_vec_t vec,
   output src_vec_t one_hot
);

   // Two's-complement trick: vec & -vec keeps only the lowest set bit.
   always_comb begin
      one_hot = vec & (~vec + src_vec_t'(1));
   end

endmodule

// File: rtl/int_ctrl.sv
// int_ctrl: small priority interrupt controller with pending, in-service and mask registers.
// Build option: define INT_CTRL_EDGE_EN for rising-edge capture of irq_in;
// otherwise requests are captured level-sensitively on every cycle they are high.
// s_calli/s_reti are single-cycle strobes from the control unit, not a handshake;
// only their lowest set bit is honoured.
module int_ctrl
   import int_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] irq_in,
   input  logic       mask_we,
   input  logic [7:0] mask_data,
   input  logic [7:0] s_calli,
   input  logic [7:0] s_reti,
   output logic [7:0] min_bit_s,
   output logic [7:0] min_bit_a,
   output logic       irq_pending,
   output logic [7:0] mask_q,
   output logic       nest_err
);

   src_vec_t pending;
   src_vec_t in_service;
   src_vec_t mask;
   src_vec_t call_k;
   src_vec_t ret_k;
   src_vec_t capture;
   src_vec_t pending_next;
   src_vec_t in_service_next;
   logic     nest_hit;

   lowbit_iso u_iso_s    (.vec(pending & mask), .one_hot(min_bit_s));
   lowbit_iso u_iso_a    (.vec(in_service),     .one_hot(min_bit_a));
   lowbit_iso u_iso_call (.vec(s_calli),        .one_hot(call_k));
   lowbit_iso u_iso_ret  (.vec(s_reti),         .one_hot(ret_k));

`ifdef INT_CTRL_EDGE_EN
   src_vec_t irq_q;

   // Edge-detect history for the external request lines.
   always_ff @(posedge clk) begin
      if (reset) irq_q <= '0;
      else       irq_q <= irq_in;
   end

   // A held-high line triggers once; it does not re-pend after being called.
   always_comb begin
      capture = irq_in & ~irq_q & ~EXC_BITS;
   end
`else
   // Level capture: a held line re-pends every cycle, even right after a call.
   always_comb begin
      capture = irq_in & ~EXC_BITS;
   end
`endif

   // Next-state for pending and in_service; capture beats a call clear, a call beats a return.
   always_comb begin
      nest_hit        = |(call_k & in_service);
      pending_next    = ((pending & ~call_k) | capture) & ~EXC_BITS;
      in_service_next = (in_service & ~(ret_k & ~call_k)) | call_k;
   end

   // State registers; reset overrides every concurrent update.
   always_ff @(posedge clk) begin
      if (reset) begin
         pending    <= '0;
         in_service <= '0;
         mask       <= MASK_RST;
         nest_err   <= 1'b0;
      end else begin
         pending    <= pending_next;
         in_service <= in_service_next;
         if (mask_we) mask <= mask_data | EXC_BITS;
         if (nest_hit) nest_err <= 1'b1;
      end
   end

   // Status outputs.
   always_comb begin
      irq_pending = |min_bit_s;
      mask_q      = mask;
   end

endmodule
